game_fsm: RTL and testbench

GAME_FSM -- requirements
Module: game_fsm

---
 rtl/game_fsm.sv | 125 ++++++++++++
 tb/tb_game_fsm.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/game_fsm.sv
// ============================================================================
// game_fsm : top-level game flow controller (cover / play / hit / bomb / end)
// Revision : 1.0
// ============================================================================
`default_nettype none

module game_fsm #(
  parameter int INIT_LIFE   = 3,
  parameter int INIT_BOMB   = 3,
  parameter int HIT_CYCLES  = 100000000,
  parameter int BOMB_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enter,
  input  logic       bomb,
  input  logic       collision,
  input  logic       die,
  output logic [3:0] game_state,
  output logic [3:0] num_life,
  output logic [3:0] num_bomb,
  output logic       game_en,
  output logic       game_reset
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0000,
    S_COVER = 4'b0001,
    S_PLAY  = 4'b0010,
    S_BOMB  = 4'b0011,
    S_WIN   = 4'b1000,
    S_OVER  = 4'b1001,
    S_HIT   = 4'b1010
  } state_t;

  localparam logic [3:0]  C_LIFE_INIT = 4'(INIT_LIFE);
  localparam logic [3:0]  C_BOMB_INIT = 4'(INIT_BOMB);
  localparam logic [31:0] C_HIT_LAST  = 32'(HIT_CYCLES - 1);
  localparam logic [31:0] C_BOMB_LAST = 32'(BOMB_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  life_q, life_d;
  logic [3:0]  bomb_cnt_q, bomb_cnt_d;
  logic [31:0] timer_q, timer_d;
  logic        enter_prev_q, bomb_prev_q;
  logic        enter_rise, bomb_rise;

  assign enter_rise = enter & ~enter_prev_q;
  assign bomb_rise  = bomb & ~bomb_prev_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      life_q       <= C_LIFE_INIT;
      bomb_cnt_q   <= C_BOMB_INIT;
      timer_q      <= '0;
      enter_prev_q <= 1'b0;
      bomb_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      life_q       <= life_d;
      bomb_cnt_q   <= bomb_cnt_d;
      timer_q      <= timer_d;
      enter_prev_q <= enter;
      bomb_prev_q  <= bomb;
    end
  end

  // Timer defaults to 0 so it only counts while a timed phase is held.
  always_comb begin
    state_d    = state_q;
    life_d     = life_q;
    bomb_cnt_d = bomb_cnt_q;
    timer_d    = '0;
    case (state_q)
      S_IDLE: begin
        life_d     = C_LIFE_INIT;
        bomb_cnt_d = C_BOMB_INIT;
        state_d    = S_COVER;
      end
      S_COVER: begin
        if (enter_rise) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (die) begin
          state_d = S_WIN;
        end else if (collision) begin
          if (life_q <= 4'd1) begin
            life_d  = 4'd0;
            state_d = S_OVER;
          end else begin
            life_d  = life_q - 4'd1;
            state_d = S_HIT;
          end
        end else if (bomb_rise && (bomb_cnt_q != 4'd0)) begin
          bomb_cnt_d = bomb_cnt_q - 4'd1;
          state_d    = S_BOMB;
        end
      end
      S_HIT: begin
        if (die)                      state_d = S_WIN;
        else if (timer_q == C_HIT_LAST) state_d = S_PLAY;
        else                          timer_d = timer_q + 32'd1;
      end
      S_BOMB: begin
        if (die)                       state_d = S_WIN;
        else if (timer_q == C_BOMB_LAST) state_d = S_PLAY;
        else                           timer_d = timer_q + 32'd1;
      end
      S_WIN, S_OVER: begin
        if (enter_rise) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign game_state = state_q;
  assign num_life   = life_q;
  assign num_bomb   = bomb_cnt_q;
  assign game_en    = (state_q == S_PLAY) || (state_q == S_HIT) || (state_q == S_BOMB);
  assign game_reset = (state_q == S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_game_fsm.sv
// ============================================================================
// tb_game_fsm : directed + randomized checks of game_fsm against a phase model
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_game_fsm;

  localparam int P_HIT  = 4;
  localparam int P_BOMB = 3;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       enter = 1'b0, bomb = 1'b0, collision = 1'b0, die = 1'b0;
  logic [3:0] game_state, num_life, num_bomb;
  logic       game_en, game_reset;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  game_fsm #(
    .INIT_LIFE(3), .INIT_BOMB(3), .HIT_CYCLES(P_HIT), .BOMB_CYCLES(P_BOMB)
  ) dut (
    .clk(clk), .rstn(rstn), .enter(enter), .bomb(bomb),
    .collision(collision), .die(die), .game_state(game_state),
    .num_life(num_life), .num_bomb(num_bomb), .game_en(game_en),
    .game_reset(game_reset)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: state code, counts, and cycles remaining in the timed phase.
  int   m_state, m_life, m_bomb, m_rem;
  logic m_ep, m_bp;

  always @(posedge clk or negedge rstn) begin : model
    int   ns, nl, nb, nr;
    logic er, br;
    if (!rstn) begin
      m_state <= 0; m_life <= 3; m_bomb <= 3; m_rem <= 0;
      m_ep <= 1'b0; m_bp <= 1'b0;
    end else begin
      er = enter && !m_ep;
      br = bomb && !m_bp;
      ns = m_state; nl = m_life; nb = m_bomb; nr = m_rem;
      case (m_state)
        0: begin nl = 3; nb = 3; ns = 1; end
        1: if (er) ns = 2;
        2: begin
          if (die) ns = 8;
          else if (collision) begin
            if (m_life <= 1) begin nl = 0; ns = 9; end
            else begin nl = m_life - 1; ns = 10; nr = P_HIT; end
          end else if (br && m_bomb > 0) begin
            nb = m_bomb - 1; ns = 3; nr = P_BOMB;
          end
        end
        3, 10: begin
          if (die) ns = 8;
          else if (m_rem == 1) ns = 2;
          else nr = m_rem - 1;
        end
        8, 9: if (er) ns = 0;
        default: ns = 0;
      endcase
      m_state <= ns; m_life <= nl; m_bomb <= nb; m_rem <= nr;
      m_ep <= enter; m_bp <= bomb;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("state", game_state, m_state);
      check("num_life", num_life, m_life);
      check("num_bomb", num_bomb, m_bomb);
      check("game_en", game_en, int'(m_state == 2 || m_state == 3 || m_state == 10));
      check("game_reset", game_reset, int'(m_state == 0));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_play();
    int n = 0;
    while (game_state != 4'd2 && n < 20) begin
      tick();
      n++;
    end
    check("wait_play", game_state, 2);
  endtask

  initial begin
    int n;
    #2 rstn = 1'b0;
    #1;
    check("rst_state", game_state, 0);
    check("rst_life", num_life, 3);
    check("rst_bomb", num_bomb, 3);
    check("rst_game_en", game_en, 0);
    check("rst_game_reset", game_reset, 1);
    chk_en = 1'b1;
    tick(); #2 rstn = 1'b1;

    // Start: COVER, then one transition to PLAY while enter is held.
    tick();
    check("cover", game_state, 1);
    enter = 1'b1;
    tick();
    check("play", game_state, 2);
    check("play_en", game_en, 1);
    repeat (9) tick();
    check("enter_held", game_state, 2);
    enter = 1'b0;

    // First collision: 4 cycles in HIT even with collision held.
    collision = 1'b1;
    tick();
    check("hit1_state", game_state, 10);
    check("hit1_life", num_life, 2);
    n = 1;
    while (game_state == 4'd10 && n < 20) begin
      tick();
      if (game_state == 4'd10) n++;
    end
    collision = 1'b0;
    check("hit_len", n, 4);
    check("hit_return", game_state, 2);

    collision = 1'b1; tick(); collision = 1'b0;
    check("hit2_life", num_life, 1);
    wait_play();
    collision = 1'b1; tick(); collision = 1'b0;
    check("over_state", game_state, 9);
    check("over_life", num_life, 0);
    check("over_en", game_en, 0);
    enter = 1'b1; tick(); enter = 1'b0;
    check("new_idle", game_state, 0);
    check("new_reset", game_reset, 1);
    tick();
    check("new_cover", game_state, 1);
    check("new_life", num_life, 3);
    check("new_bomb", num_bomb, 3);
    enter = 1'b1; tick(); enter = 1'b0;

    // Bombs: three usable, each 3 cycles; fourth press ignored.
    for (int k = 0; k < 3; k++) begin
      bomb = 1'b1; tick(); bomb = 1'b0;
      check("bomb_state", game_state, 3);
      check("bomb_cnt", num_bomb, 2 - k);
      n = 1;
      while (game_state == 4'd3 && n < 20) begin
        tick();
        if (game_state == 4'd3) n++;
      end
      check("bomb_len", n, 3);
    end
    bomb = 1'b1; tick(); bomb = 1'b0; tick();
    check("bomb_empty_state", game_state, 2);
    check("bomb_empty_cnt", num_bomb, 0);

    // die wins over collision.
    die = 1'b1; collision = 1'b1; tick(); die = 1'b0; collision = 1'b0;
    check("win_state", game_state, 8);
    check("win_life", num_life, 3);
    enter = 1'b1; tick(); enter = 1'b0;
    check("win_idle", game_state, 0);
    tick();
    enter = 1'b1; tick(); enter = 1'b0;

    // Asynchronous reset in BOMB with timer at 2.
    bomb = 1'b1; tick(); bomb = 1'b0;
    tick(); tick();
    check("bomb_t2_state", game_state, 3);
    #2 rstn = 1'b0;
    #1;
    check("arst_state", game_state, 0);
    check("arst_bomb", num_bomb, 3);
    check("arst_life", num_life, 3);
    check("arst_reset", game_reset, 1);
    tick(); #2 rstn = 1'b1;
    tick();
    check("arst_cover", game_state, 1);

    repeat (4000) begin
      tick();
      enter     = ($urandom_range(0, 3) == 0);
      bomb      = ($urandom_range(0, 4) == 0);
      collision = ($urandom_range(0, 11) == 0);
      die       = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rstn = 1'b0;
        tick();
        #2 rstn = 1'b1;
      end
    end
    tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
